// File: rtl/cpu_pkg.sv
// Opcodes, ALU codes, state and control-vector types shared by the control sequencer.
// CTRL_SEQ_MULDIV_EN makes mul (15) and div (16) legal opcodes.
package cpu_pkg;

    localparam int OPCODE_W_DEFAULT = 5;

    localparam int unsigned OP_LD   = 0;
    localparam int unsigned OP_LDI  = 1;
    localparam int unsigned OP_ST   = 2;
    localparam int unsigned OP_ADD  = 3;
    localparam int unsigned OP_SHL  = 11;
    localparam int unsigned OP_ADDI = 12;
    localparam int unsigned OP_ANDI = 13;
    localparam int unsigned OP_ORI  = 14;
    localparam int unsigned OP_MUL  = 15;
    localparam int unsigned OP_DIV  = 16;
    localparam int unsigned OP_HALT = 27;

    localparam int unsigned ALU_ADD = 3;
    localparam int unsigned ALU_AND = 5;
    localparam int unsigned ALU_OR  = 6;

`ifdef CTRL_SEQ_MULDIV_EN
    localparam bit MULDIV_LEGAL = 1'b1;
`else
    localparam bit MULDIV_LEGAL = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_IDLE = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        C_LD,
        C_LDI,
        C_ST,
        C_RTYPE,
        C_IMM,
        C_MULDIV,
        C_HALT,
        C_ILLEGAL
    } instr_class_t;

    typedef struct packed {
        logic pc_select;
        logic mar_enable;
        logic pc_increment_enable;
        logic read;
        logic write;
        logic mdr_enable;
        logic mdr_select;
        logic ir_enable;
        logic gra;
        logic grb;
        logic grc;
        logic ba_out;
        logic r_out;
        logic r_enable;
        logic y_enable;
        logic z_enable;
        logic c_select;
        logic z_lo_select;
        logic z_hi_select;
        logic lo_enable;
        logic hi_enable;
        logic last_step;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic instr_class_t classify(input logic [31:0] op);
        instr_class_t cls;
        if (op == OP_LD)                        cls = C_LD;
        else if (op == OP_LDI)                  cls = C_LDI;
        else if (op == OP_ST)                   cls = C_ST;
        else if (op >= OP_ADD && op <= OP_SHL)  cls = C_RTYPE;
        else if (op >= OP_ADDI && op <= OP_ORI) cls = C_IMM;
        else if (op == OP_HALT)                 cls = C_HALT;
        else if ((op == OP_MUL || op == OP_DIV) && MULDIV_LEGAL) cls = C_MULDIV;
        else                                    cls = C_ILLEGAL;
        return cls;
    endfunction

    function automatic logic [31:0] imm_alu(input logic [31:0] op);
        logic [31:0] code;
        if (op == OP_ANDI)     code = ALU_AND;
        else if (op == OP_ORI) code = ALU_OR;
        else                   code = ALU_ADD;
        return code;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (step, opcode) to the control vector, ALU code and
// step-sequencing hints (final step, halt, illegal, memory-wait step).
module ctrl_decode
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_W_DEFAULT,
    parameter int ALU_OP_W = 5
) (
    input  logic [3:0]          state,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [ALU_OP_W-1:0] alu_instruction,
    output logic                to_halt,
    output logic                illegal_op,
    output logic                mem_step
);

    state_t       st;
    instr_class_t cls;
    logic [31:0]  op_val;
    ctrl_t        c;

    assign st     = state_t'(state);
    assign op_val = 32'(opcode);
    assign cls    = classify(op_val);
    assign ctrl   = c;

    always_comb begin
        c               = '0;
        alu_instruction = '0;
        to_halt         = 1'b0;
        illegal_op      = 1'b0;
        mem_step        = 1'b0;
        case (st)
            S_T0: begin
                c.pc_select  = 1'b1;
                c.mar_enable = 1'b1;
            end
            S_T1: begin
                c.pc_increment_enable = 1'b1;
                c.read                = 1'b1;
                c.mdr_enable          = 1'b1;
                mem_step              = 1'b1;
            end
            S_T2: begin
                c.mdr_select = 1'b1;
                c.ir_enable  = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_LD, C_LDI, C_ST: begin
                        c.grb      = 1'b1;
                        c.ba_out   = 1'b1;
                        c.y_enable = 1'b1;
                    end
                    C_RTYPE, C_IMM: begin
                        c.grb      = 1'b1;
                        c.r_out    = 1'b1;
                        c.y_enable = 1'b1;
                    end
                    C_MULDIV: begin
                        c.gra      = 1'b1;
                        c.r_out    = 1'b1;
                        c.y_enable = 1'b1;
                    end
                    C_HALT:  to_halt = 1'b1;
                    default: begin
                        illegal_op  = 1'b1;
                        c.last_step = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                c.z_enable = 1'b1;
                case (cls)
                    C_LD, C_LDI, C_ST: begin
                        c.c_select      = 1'b1;
                        alu_instruction = ALU_OP_W'(ALU_ADD);
                    end
                    C_RTYPE: begin
                        c.grc           = 1'b1;
                        c.r_out         = 1'b1;
                        alu_instruction = ALU_OP_W'(op_val);
                    end
                    C_IMM: begin
                        c.c_select      = 1'b1;
                        alu_instruction = ALU_OP_W'(imm_alu(op_val));
                    end
                    C_MULDIV: begin
                        c.grb           = 1'b1;
                        c.r_out         = 1'b1;
                        alu_instruction = ALU_OP_W'(op_val);
                    end
                    default: c.z_enable = 1'b0;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_LD, C_ST: begin
                        c.z_lo_select = 1'b1;
                        c.mar_enable  = 1'b1;
                    end
                    C_LDI, C_RTYPE, C_IMM: begin
                        c.z_lo_select = 1'b1;
                        c.gra         = 1'b1;
                        c.r_enable    = 1'b1;
                        c.last_step   = 1'b1;
                    end
                    C_MULDIV: begin
                        c.z_lo_select = 1'b1;
                        c.lo_enable   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        c.read       = 1'b1;
                        c.mdr_enable = 1'b1;
                        mem_step     = 1'b1;
                    end
                    C_ST: begin
                        c.gra        = 1'b1;
                        c.r_out      = 1'b1;
                        c.mdr_enable = 1'b1;
                    end
                    C_MULDIV: begin
                        c.z_hi_select = 1'b1;
                        c.hi_enable   = 1'b1;
                        c.last_step   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin
                        c.mdr_select = 1'b1;
                        c.gra        = 1'b1;
                        c.r_enable   = 1'b1;
                        c.last_step  = 1'b1;
                    end
                    C_ST: begin
                        c.write     = 1'b1;
                        mem_step    = 1'b1;
                        c.last_step = 1'b1;
                    end
                    default: c.last_step = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control sequencer: state register, memory wait counter, opcode latch and illegal flag.
// Building with CTRL_SEQ_MULDIV_EN adds the mul/div sequence (decoded via cpu_pkg).
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_W_DEFAULT,
    parameter int ALU_OP_W = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                run,
    input  logic                stall,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                PC_select,
    output logic                MAR_enable,
    output logic                PC_increment_enable,
    output logic                read,
    output logic                write,
    output logic                MDR_enable,
    output logic                MDR_select,
    output logic                IR_enable,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                BAout,
    output logic                Rout,
    output logic                r_enable,
    output logic                Y_enable,
    output logic                Z_enable,
    output logic                c_select,
    output logic                Z_LO_select,
    output logic                Z_HI_select,
    output logic                LO_enable,
    output logic                HI_enable,
    output logic [ALU_OP_W-1:0] alu_instruction,
    output logic [3:0]          step,
    output logic                done,
    output logic                illegal
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t              state_reg;
    state_t              state_next;
    logic [2:0]          wait_cnt_reg;
    logic [OPCODE_W-1:0] opcode_reg;
    logic                illegal_reg;

    logic [OPCODE_W-1:0] dec_opcode;
    logic [CTRL_W-1:0]   ctrl_bits;
    ctrl_t               ctrl;
    logic                to_halt;
    logic                illegal_op;
    logic                mem_step;
    logic [2:0]          wait_limit;
    logic                wait_done;
    logic                advance;

    // IR is only valid from T3 on, so T3 decodes the live opcode and later steps the latched copy.
    assign dec_opcode = (state_reg == S_T3) ? opcode : opcode_reg;

    ctrl_decode #(
        .OPCODE_W(OPCODE_W),
        .ALU_OP_W(ALU_OP_W)
    ) u_decode (
        .state           (state_reg),
        .opcode          (dec_opcode),
        .ctrl            (ctrl_bits),
        .alu_instruction (alu_instruction),
        .to_halt         (to_halt),
        .illegal_op      (illegal_op),
        .mem_step        (mem_step)
    );

    assign ctrl       = ctrl_t'(ctrl_bits);
    assign wait_limit = mem_step ? WAIT_LAST : 3'd0;
    assign wait_done  = (wait_cnt_reg == wait_limit);
    assign advance    = !stall && wait_done;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (run) state_next = S_T0;
            S_HALT: state_next = S_HALT;
            default: begin
                if (ctrl.last_step)  state_next = S_T0;
                else if (to_halt)    state_next = S_HALT;
                else                 state_next = state_t'(state_reg + 4'd1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            opcode_reg   <= '0;
            illegal_reg  <= 1'b0;
        end else if (!stall) begin
            if (wait_done) begin
                state_reg    <= state_next;
                wait_cnt_reg <= '0;
                if (state_reg == S_T3) begin
                    opcode_reg <= opcode;
                    if (illegal_op) illegal_reg <= 1'b1;
                end
            end else begin
                wait_cnt_reg <= wait_cnt_reg + 3'd1;
            end
        end
    end

    assign PC_select           = ctrl.pc_select;
    assign MAR_enable          = ctrl.mar_enable;
    assign PC_increment_enable = ctrl.pc_increment_enable;
    assign read                = ctrl.read;
    assign write               = ctrl.write;
    assign MDR_enable          = ctrl.mdr_enable;
    assign MDR_select          = ctrl.mdr_select;
    assign IR_enable           = ctrl.ir_enable;
    assign Gra                 = ctrl.gra;
    assign Grb                 = ctrl.grb;
    assign Grc                 = ctrl.grc;
    assign BAout               = ctrl.ba_out;
    assign Rout                = ctrl.r_out;
    assign r_enable            = ctrl.r_enable;
    assign Y_enable            = ctrl.y_enable;
    assign Z_enable            = ctrl.z_enable;
    assign c_select            = ctrl.c_select;
    assign Z_LO_select         = ctrl.z_lo_select;
    assign Z_HI_select         = ctrl.z_hi_select;
    assign LO_enable           = ctrl.lo_enable;
    assign HI_enable           = ctrl.hi_enable;
    // done marks only the cycle that actually leaves the final step, so stalls and waits never repeat it.
    assign done                = ctrl.last_step && advance;
    assign step                = state_reg;
    assign illegal             = illegal_reg;

endmodule
